// File: rtl/sensor_init_seq.sv
// sensor_init_seq: walks a parameter ROM of {register address, register data}
// entries from index 0 up and issues each one as a write request to the I2C/SCCB
// master. An entry whose address equals DELAY_ADDR is a delay pseudo-entry: it
// waits data x DELAY_TICKS clocks and is never put on the bus. A NACKed write is
// re-issued up to MAX_RETRY times before the sequence stops in ERROR with the
// failing index latched. All outputs come straight from flops.
module sensor_init_seq #(
   parameter int REG_ADDR_W  = 16,
   parameter int REG_DATA_W  = 8,
   parameter int INIT_DEPTH  = 313,
   parameter bit [INIT_DEPTH-1:0][REG_ADDR_W+REG_DATA_W-1:0] INIT_ROM = '0,
   parameter bit [REG_ADDR_W-1:0] DELAY_ADDR = '1,
   parameter int DELAY_TICKS = 100000,
   parameter int MAX_RETRY   = 3
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                start_i,
   output logic                                wr_valid_o,
   input  logic                                wr_ready_i,
   output logic [REG_ADDR_W-1:0]               wr_addr_o,
   output logic [REG_DATA_W-1:0]               wr_data_o,
   input  logic                                wr_done_i,
   input  logic                                wr_nack_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                err_o,
   output logic [$clog2(INIT_DEPTH+1)-1:0]     err_idx_o,
   output logic [$clog2(INIT_DEPTH+1)-1:0]     op_idx_o
);

   localparam int     ENTRY_W = REG_ADDR_W + REG_DATA_W;
   localparam int     IDX_W   = $clog2(INIT_DEPTH + 1);
   localparam int     ROM_AW  = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
   localparam longint MAX_CNT = ((longint'(1) << REG_DATA_W) - 1) * longint'(DELAY_TICKS);
   localparam int     CNT_W   = $clog2(MAX_CNT + 1);
   // A zero-retry build still needs a one-bit counter to keep the logic uniform.
   localparam int     RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT_ACK,
      S_DELAY,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [IDX_W-1:0]        err_idx_q, err_idx_d;
   logic [RTY_W-1:0]        rty_q, rty_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0]   addr_q, addr_d;
   logic [REG_DATA_W-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic [ENTRY_W-1:0]      rom_entry;
   logic [REG_ADDR_W-1:0]   rom_addr;
   logic [REG_DATA_W-1:0]   rom_data;
   logic                    last_entry;
   logic                    advance;

   assign rom_entry  = INIT_ROM[idx_q[ROM_AW-1:0]];
   assign rom_addr   = rom_entry[ENTRY_W-1 -: REG_ADDR_W];
   assign rom_data   = rom_entry[REG_DATA_W-1:0];
   assign last_entry = (idx_q == IDX_W'(INIT_DEPTH - 1));

   // Next-state, datapath updates and registered-output decode.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      err_idx_d = err_idx_q;
      rty_d     = rty_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      advance   = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               state_d   = S_FETCH;
               idx_d     = '0;
               err_idx_d = '0;
            end
         end
         S_FETCH: begin
            rty_d = '0;
            if (rom_addr == DELAY_ADDR) begin
               // Delay entries load the counter only; the bus-facing holding
               // registers keep the last real write.
               cnt_d   = CNT_W'(rom_data) * CNT_W'(DELAY_TICKS);
               state_d = S_DELAY;
            end else begin
               addr_d  = rom_addr;
               data_d  = rom_data;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wr_ready_i) begin
               state_d = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (wr_done_i) begin
               if (!wr_nack_i) begin
                  advance = 1'b1;
               end else if (rty_q < RTY_W'(MAX_RETRY)) begin
                  rty_d   = rty_q + RTY_W'(1);
                  state_d = S_ISSUE;
               end else begin
                  err_idx_d = idx_q;
                  state_d   = S_ERROR;
               end
            end
         end
         S_DELAY: begin
            // A count of 0 or 1 both leave after this cycle, so data 0 costs one cycle.
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (advance) begin
         if (last_entry) begin
            state_d = S_DONE;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
         end
      end

      // Status flags are decoded from the next state so they are registered
      // and line up with the state they describe.
      valid_d = (state_d == S_ISSUE);
      busy_d  = (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                (state_d == S_WAIT_ACK) || (state_d == S_DELAY);
      done_d  = (state_d == S_DONE);
      err_d   = (state_d == S_ERROR);
   end

   // State and output registers; reset returns everything to idle at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         err_idx_q <= '0;
         rty_q     <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         err_idx_q <= err_idx_d;
         rty_q     <= rty_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign wr_valid_o = valid_q;
   assign wr_addr_o  = addr_q;
   assign wr_data_o  = data_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign err_idx_o  = err_idx_q;
   assign op_idx_o   = idx_q;

endmodule

// File: tb/tb_sensor_init_seq.sv
// Bench for sensor_init_seq: a reference model expands each run plan (per-entry
// NACK counts) into the expected sequence of bus writes with their start gaps,
// plus the final done/error record; a slave model answers handshakes and a
// monitor pops and compares whatever the DUT presents.
module tb_sensor_init_seq;

   localparam int AW     = 16;
   localparam int DW     = 8;
   localparam int DEPTH  = 6;
   localparam int TICKS  = 4;
   localparam int MRETRY = 2;
   localparam int IW     = $clog2(DEPTH + 1);

   localparam bit [DEPTH-1:0][AW+DW-1:0] ROM = {
      24'h0300AA, 24'hFFFF00, 24'h010001, 24'hFFFF05, 24'h013618, 24'h010000
   };

   localparam int EV_WRITE = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_ERR   = 2;

   typedef struct {
      int            kind;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            idx;
      int            gap;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          wr_valid_o;
   logic          wr_ready_i;
   logic [AW-1:0] wr_addr_o;
   logic [DW-1:0] wr_data_o;
   logic          wr_done_i;
   logic          wr_nack_i;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic [IW-1:0] err_idx_o;
   logic [IW-1:0] op_idx_o;

   ev_t ev_q[$];
   bit  nack_q[$];
   int  nk_g[DEPTH];
   int  checks   = 0;
   int  failures = 0;
   bit  bp       = 1'b0;

   always #5 clk = ~clk;

   sensor_init_seq #(
      .REG_ADDR_W (AW),
      .REG_DATA_W (DW),
      .INIT_DEPTH (DEPTH),
      .INIT_ROM   (ROM),
      .DELAY_ADDR (16'hFFFF),
      .DELAY_TICKS(TICKS),
      .MAX_RETRY  (MRETRY)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start_i),
      .wr_valid_o(wr_valid_o),
      .wr_ready_i(wr_ready_i),
      .wr_addr_o (wr_addr_o),
      .wr_data_o (wr_data_o),
      .wr_done_i (wr_done_i),
      .wr_nack_i (wr_nack_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .err_idx_o (err_idx_o),
      .op_idx_o  (op_idx_o)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: from the ROM contents and the NACK plan, list every
   // write the bus should see, the cycles from the triggering event (start or
   // previous wr_done_i) to its wr_valid_o, and how the run must end.
   task automatic plan_run();
      int            gap;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            nacked;
      ev_t           e;
      gap = 2;
      for (int i = 0; i < DEPTH; i++) begin
         a = ROM[i][AW+DW-1:DW];
         d = ROM[i][DW-1:0];
         if (a == 16'hFFFF) begin
            gap += 1 + ((d == 0) ? 1 : int'(d) * TICKS);
            continue;
         end
         for (int t = 0; t <= MRETRY; t++) begin
            nacked = (t < nk_g[i]);
            e.kind = EV_WRITE; e.addr = a; e.data = d; e.idx = i; e.gap = gap;
            ev_q.push_back(e);
            nack_q.push_back(nacked);
            if (!nacked) begin
               gap = 2;
               break;
            end
            gap = 1;
            if (t == MRETRY) begin
               e.kind = EV_ERR; e.addr = '0; e.data = '0; e.idx = i; e.gap = 1;
               ev_q.push_back(e);
               return;
            end
         end
      end
      e.kind = EV_DONE; e.addr = '0; e.data = '0; e.idx = DEPTH - 1; e.gap = gap - 1;
      ev_q.push_back(e);
   endtask

   // Slave: random ready, random completion latency, stray done/nack pulses
   // only where the sequencer cannot be waiting for an acknowledge.
   initial begin
      int dcnt;
      bit cur_nack;
      bit hs;
      dcnt = 0; cur_nack = 1'b0;
      wr_ready_i = 1'b0; wr_done_i = 1'b0; wr_nack_i = 1'b0;
      forever begin
         @(negedge clk);
         hs = wr_valid_o && wr_ready_i && !rst;
         @(posedge clk);
         #1;
         wr_done_i = 1'b0;
         wr_nack_i = ($urandom_range(0, 3) == 0);
         if (rst) begin
            dcnt = 0;
         end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
               wr_done_i = 1'b1;
               wr_nack_i = cur_nack;
            end
         end else if (hs) begin
            dcnt = $urandom_range(1, 4);
            cur_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
         end else if ($urandom_range(0, 7) == 0) begin
            wr_done_i = 1'b1;
         end
         wr_ready_i = (bp || rst) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops an expected event for every wr_valid_o rise and every
   // done_o / err_o rise, and checks the interface rules in between.
   initial begin
      int            cyc, ref_t;
      bit            pend, pv, phs, pd, pe;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;
      ev_t           e;
      cyc = 0; ref_t = 0; pend = 0; pv = 0; phs = 0; pd = 0; pe = 0;
      ha = '0; hd = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            pend = 0; pv = 0; phs = 0; pd = 0; pe = 0;
            continue;
         end
         if (start_i && !busy_o) ref_t = cyc;
         if (wr_done_i && pend) begin
            ref_t = cyc;
            pend = 0;
         end
         if (pv && !phs) chk("valid_held_until_ready", 64'(wr_valid_o), 64'(1));
         if (wr_valid_o && !pv) begin
            checks++;
            if (ev_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write actual=%0h/%0h required=no_write", wr_addr_o, wr_data_o);
            end else begin
               e = ev_q.pop_front();
               if (e.kind != EV_WRITE) begin
                  failures++;
                  $display("FAIL event_order actual=write required_kind=%0d", e.kind);
               end else begin
                  chk("write_gap", 64'(cyc - ref_t), 64'(e.gap));
                  chk("write_addr", 64'(wr_addr_o), 64'(e.addr));
                  chk("write_data", 64'(wr_data_o), 64'(e.data));
                  chk("write_op_idx", 64'(op_idx_o), 64'(e.idx));
               end
            end
            ha = wr_addr_o;
            hd = wr_data_o;
         end else if (wr_valid_o) begin
            chk("addr_stable", 64'(wr_addr_o), 64'(ha));
            chk("data_stable", 64'(wr_data_o), 64'(hd));
         end
         if (wr_valid_o) chk("valid_implies_busy", 64'(busy_o), 64'(1));
         phs = wr_valid_o && wr_ready_i;
         if (phs) pend = 1;
         if ((done_o && !pd) || (err_o && !pe)) begin
            checks++;
            if (ev_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_end actual=done%0d_err%0d required=none", done_o, err_o);
            end else begin
               e = ev_q.pop_front();
               chk("end_kind", 64'(done_o ? EV_DONE : EV_ERR), 64'(e.kind));
               chk("end_gap", 64'(cyc - ref_t), 64'(e.gap));
               chk("end_busy", 64'(busy_o), 64'(0));
               chk("end_op_idx", 64'(op_idx_o), 64'(e.idx));
               if (e.kind == EV_ERR) begin
                  chk("err_idx", 64'(err_idx_o), 64'(e.idx));
                  chk("err_no_done", 64'(done_o), 64'(0));
               end else begin
                  chk("done_no_err", 64'(err_o), 64'(0));
               end
            end
         end
         pv = wr_valid_o;
         pd = done_o;
         pe = err_o;
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_end();
      int k;
      for (k = 0; k < 4000; k++) begin
         @(posedge clk);
         if (ev_q.size() == 0) break;
      end
      checks++;
      if (k >= 4000) begin
         failures++;
         $display("FAIL run_timeout actual=%0d_events_left required=0", ev_q.size());
         ev_q.delete();
         nack_q.delete();
      end
      repeat (6) @(posedge clk);
      #1;
      chk("all_planned_handshakes_taken", 64'(nack_q.size()), 64'(0));
   endtask

   task automatic do_run(input bit bp_test, input bit busy_start);
      int k;
      plan_run();
      pulse_start();
      chk("start_clears_err", 64'(err_o), 64'(0));
      chk("start_clears_done", 64'(done_o), 64'(0));
      chk("start_sets_busy", 64'(busy_o), 64'(1));
      if (bp_test) begin
         for (k = 0; k < 200; k++) begin
            @(posedge clk); #2;
            if (wr_valid_o && !wr_ready_i) break;
         end
         chk("bp_found_valid", 64'(k < 200), 64'(1));
         bp = 1'b1;
         repeat (20) @(posedge clk);
         #2;
         chk("bp_valid_after_hold", 64'(wr_valid_o), 64'(1));
         bp = 1'b0;
      end
      if (busy_start) begin
         repeat (6) @(posedge clk);
         #1;
         chk("busy_before_ignored_start", 64'(busy_o), 64'(1));
         start_i = 1'b1;
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      wait_end();
   endtask

   task automatic set_plan(input int v);
      for (int i = 0; i < DEPTH; i++) nk_g[i] = v;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      rst = 1'b1;
      start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(wr_valid_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_done", 64'(done_o), 64'(0));
      chk("rst_err", 64'(err_o), 64'(0));
      chk("rst_op_idx", 64'(op_idx_o), 64'(0));
      chk("rst_err_idx", 64'(err_idx_o), 64'(0));
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_no_busy", 64'(busy_o), 64'(0));

      set_plan(0);  do_run(1'b0, 1'b0);
      set_plan(0);  do_run(1'b1, 1'b0);
      set_plan(0);  nk_g[1] = 2; do_run(1'b0, 1'b0);
      set_plan(0);  nk_g[1] = 3; do_run(1'b0, 1'b0);
      set_plan(0);  do_run(1'b0, 1'b1);
      repeat (6) begin
         for (int i = 0; i < DEPTH; i++) nk_g[i] = $urandom_range(0, 3);
         do_run(1'b0, 1'b0);
      end

      // Asynchronous reset while a later entry is being offered.
      set_plan(0);
      plan_run();
      pulse_start();
      for (k = 0; k < 500; k++) begin
         @(posedge clk); #1;
         if (wr_valid_o && op_idx_o != 0) break;
      end
      chk("reached_later_issue", 64'(k < 500), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(wr_valid_o), 64'(0));
      chk("async_rst_busy", 64'(busy_o), 64'(0));
      chk("async_rst_done", 64'(done_o), 64'(0));
      chk("async_rst_err", 64'(err_o), 64'(0));
      chk("async_rst_op_idx", 64'(op_idx_o), 64'(0));
      ev_q.delete();
      nack_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_idle", 64'(busy_o), 64'(0));
      set_plan(0);  do_run(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sensor_init_seq.md
# sensor_init_seq

Parametrised sensor register-initialisation sequencer that replaces the fixed-length init ROM package. It walks a parameter ROM of {register address, register data} entries, from index 0 up, and issues each entry as a write request to the downstream I2C/SCCB master. It adds:

- delay pseudo-entries;
- bounded NACK retry;
- restart on command;
- done/error status with the failing index.

It sits between the CSI-2 receiver's control/CSR logic and the I2C master.

## Interface

**Parameters**

- REG_ADDR_W, 16, sensor register address width.
- REG_DATA_W, 8, sensor register data width.
- INIT_DEPTH, 313, number of ROM entries; must be ≥ 1.
- INIT_ROM, all zeros, bit [INIT_DEPTH-1:0][REG_ADDR_W+REG_DATA_W-1:0]; entry = {addr, data}; index 0 is issued first.
- DELAY_ADDR, all ones (REG_ADDR_W bits), address marking a delay pseudo-entry; never sent on the bus.
- DELAY_TICKS, 100000, clocks per delay unit (1 ms at 100 MHz); must be ≥ 1.
- MAX_RETRY, 3, re-issues allowed per entry after a NACK; 0 disables retry.

**Ports**

- clk_i, input, 1, clock.
- rst_i, input, 1, reset; asynchronous, active-high.
- start_i, input, 1, one-cycle pulse; starts the sequence from index 0.
- wr_valid_o, output, 1, write request valid.
- wr_ready_i, input, 1, master accepts the request.
- wr_addr_o, output, REG_ADDR_W, register address.
- wr_data_o, output, REG_DATA_W, register data.
- wr_done_i, input, 1, one-cycle pulse: the accepted transfer has completed.
- wr_nack_i, input, 1, sampled with wr_done_i; 1 = the transfer was NACKed.
- busy_o, output, 1, sequence in progress.
- done_o, output, 1, sticky; all entries completed.
- err_o, output, 1, sticky; an entry failed after all retries.
- err_idx_o, output, $clog2(INIT_DEPTH+1), index of the failing entry.
- op_idx_o, output, $clog2(INIT_DEPTH+1), index currently being processed.

## Operation

- **States:** IDLE, FETCH, ISSUE, WAIT_ACK, DELAY, DONE, ERROR.
- **Reset state:** IDLE. All outputs are 0, index = 0, retry counter = 0, delay counter = 0.
- **Start:** IDLE, DONE or ERROR plus start_i → FETCH. On that transition: index cleared to 0, done_o and err_o cleared, err_idx_o cleared. start_i in any other state is ignored.
- **FETCH:** registers INIT_ROM[index] into the addr/data holding registers and clears the retry counter.
  - Next state is DELAY if the fetched address equals DELAY_ADDR.
  - Otherwise next state is ISSUE.
- **ISSUE:**
  - wr_valid_o = 1; wr_addr_o and wr_data_o hold the fetched entry and stay stable until the handshake.
  - When wr_valid_o && wr_ready_i: move to WAIT_ACK and drop wr_valid_o the following cycle.
- **WAIT_ACK:** wait for wr_done_i.
  - ACK (wr_nack_i = 0): advance.
  - NACK with retry counter < MAX_RETRY: increment the retry counter and return to ISSUE with the same entry.
  - NACK with retry counter = MAX_RETRY: go to ERROR and set err_idx_o = index.
- **DELAY:**
  - Load the counter with data × DELAY_TICKS and count down to 0, then advance.
  - Data = 0 means advance after 1 cycle in DELAY.
  - Counter width is $clog2((2^REG_DATA_W − 1) × DELAY_TICKS + 1).
  - Nothing is driven on the write interface during DELAY.
- **Advance:**
  - If index = INIT_DEPTH−1: go to DONE.
  - Otherwise increment index and go to FETCH.
- **DONE:** done_o = 1.
- **ERROR:** err_o = 1.
- **busy_o:** 1 in FETCH, ISSUE, WAIT_ACK and DELAY.
- **op_idx_o:** equals the index register at all times.
- **Stray inputs:** wr_done_i outside WAIT_ACK is ignored; wr_nack_i without wr_done_i is ignored.
- **Reset mid-operation:** immediately returns to IDLE with wr_valid_o = 0. The I2C master shares rst_i so that no transfer is left orphaned.

## Timing

- start_i at cycle 0 → FETCH at cycle 1 → wr_valid_o = 1 at cycle 2, or DELAY entered at cycle 2.
- Handshake at cycle n → WAIT_ACK at n+1, wr_valid_o = 0 at n+1.
- wr_done_i at cycle m, ACK → FETCH at m+1 → next wr_valid_o at m+2. Per-entry overhead is 2 cycles plus bus time.
- wr_done_i at cycle m, NACK with retry → wr_valid_o = 1 again at m+1.
- Delay entry with data d: d × DELAY_TICKS cycles in DELAY (1 cycle if d = 0), then FETCH.
- Last entry ACKed at cycle m → done_o = 1 and busy_o = 0 at m+1.
- wr_valid_o, once asserted, never deasserts before wr_ready_i unless reset.
- All outputs are registered.

## Test plan

- **Full sequence:** INIT_DEPTH=3, ROM {0100_00, 0136_18, 0100_01}, slave always ACK, wr_ready_i random. Required: writes appear in the order 0100/00, 0136/18, 0100/01; done_o = 1 one cycle after the third wr_done_i; err_o = 0.
- **Backpressure:** hold wr_ready_i = 0 for 20 cycles. Required: wr_valid_o, wr_addr_o and wr_data_o stay stable; exactly one transfer per entry.
- **Delay entry:** DELAY_TICKS=4, entry {FFFF, 05} between two writes. Required: exactly 20 cycles in DELAY, no wr_valid_o; data 00 gives a 1-cycle DELAY.
- **Retry:** MAX_RETRY=2, entry index 1 NACKed twice then ACKed. Required: three issues of the same addr/data, then done_o = 1. NACKed three times instead: err_o = 1, err_idx_o = 1, busy_o = 0, no further writes.
- **Restart:** start_i pulse after ERROR. Required: err_o cleared, sequence reissues from index 0. start_i pulse while busy: ignored, sequence unaffected.
- **Async reset:** assert rst_i mid-ISSUE, between clock edges. Required: wr_valid_o, busy_o, done_o, err_o and op_idx_o all 0 immediately; sequence restarts cleanly at the next start_i.
